// File: rtl/sonar_scan_sched.sv
// sonar_scan_sched: round-robin HC-SR04 scheduler; fires one sensor, times its echo, reports centimetres.
// Latency: enable in IDLE -> trig 1 cycle; echo fall at pin -> dist_valid 3 cycles (2 sync stages + report).
// Backpressure: none; each report is a one-cycle strobe, data held until the next report.
//
// Ports:
//   clk_50m, rst_n      50 MHz clock, asynchronous active-low reset
//   enable              level, keep scanning while high
//   echo[NUM_SENS]      raw echo pins, asynchronous to clk_50m
//   trig[NUM_SENS]      trigger pins, at most one high at a time
//   dist_cm, dist_id    distance (16'hFFFF on timeout) and sensor index of the last report
//   dist_valid          one-cycle strobe marking a new report
//   timeout             qualifies dist_valid: 1 = no valid echo
//   busy                high whenever the scheduler is not idle
module sonar_scan_sched #(
   parameter  int NUM_SENS         = 4,
   parameter  int TRIG_CYC         = 500,
   parameter  int ECHO_TIMEOUT_CYC = 1500000,
   parameter  int CYC_PER_CM       = 2900,
   parameter  int GUARD_CYC        = 3000000,
   localparam int IDW              = (NUM_SENS > 2) ? $clog2(NUM_SENS) : 1
) (
   input  logic                clk_50m,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [NUM_SENS-1:0] echo,
   output logic [NUM_SENS-1:0] trig,
   output logic [15:0]         dist_cm,
   output logic [IDW-1:0]      dist_id,
   output logic                dist_valid,
   output logic                timeout,
   output logic                busy
);

   // TRIG and GUARD never overlap, so they share one phase counter.
   localparam int PH_MAX = (TRIG_CYC > GUARD_CYC) ? TRIG_CYC : GUARD_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TMO_W  = $clog2(ECHO_TIMEOUT_CYC + 1);
   localparam int SUB_W  = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

   localparam logic [PH_W-1:0]  TRIG_LAST  = PH_W'(TRIG_CYC - 1);
   localparam logic [PH_W-1:0]  GUARD_LAST = PH_W'(GUARD_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ECHO_TIMEOUT_CYC - 1);
   localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CYC_PER_CM - 1);
   localparam logic [15:0]      CM_SAT     = 16'hFFFE;
   localparam logic [15:0]      CM_NONE    = 16'hFFFF;
   localparam logic [IDW-1:0]   PTR_LAST   = IDW'(NUM_SENS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_REPORT,
      S_GUARD
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                rpt_tmo;

   logic [NUM_SENS-1:0] echo_s1;
   logic [NUM_SENS-1:0] echo_s2;
   logic                echo_cur;
   logic                echo_d;
   logic                echo_rise;

   logic [IDW-1:0]      ptr;
   logic [NUM_SENS-1:0] ptr_onehot;
   logic [PH_W-1:0]     ph_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [SUB_W-1:0]    sub_cnt;
   logic [15:0]         cm_cnt;

   logic                trig_done;
   logic                guard_done;
   logic                tmo_hit;
   logic                count_en;
   logic [SUB_W-1:0]    sub_base;
   logic [SUB_W-1:0]    sub_inc;
   logic [15:0]         cm_base;
   logic [15:0]         cm_inc;

   // Two-stage synchroniser on every echo line; only the selected bit is used.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         echo_s1 <= '0;
         echo_s2 <= '0;
         echo_d  <= 1'b0;
      end else begin
         echo_s1 <= echo;
         echo_s2 <= echo_s1;
         echo_d  <= echo_cur;
      end
   end

   // echo_d follows the selected sensor through TRIG, so a line that is
   // already high when WAIT_RISE starts does not look like a rising edge.
   assign echo_cur  = echo_s2[ptr];
   assign echo_rise = echo_cur & ~echo_d;

   assign trig_done  = (ph_cnt == TRIG_LAST);
   assign guard_done = (ph_cnt == GUARD_LAST);
   assign tmo_hit    = (tmo_cnt == TMO_LAST);

   always_comb begin
      ptr_onehot      = '0;
      ptr_onehot[ptr] = 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; the timeout is tested first so it wins over a
   // simultaneous echo fall or rise.
   always_comb begin
      state_nxt = state;
      rpt_tmo   = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) begin
               state_nxt = S_TRIG;
            end
         end
         S_TRIG: begin
            if (trig_done) begin
               state_nxt = S_WAIT_RISE;
            end
         end
         S_WAIT_RISE: begin
            if (tmo_hit) begin
               state_nxt = S_REPORT;
               rpt_tmo   = 1'b1;
            end else if (echo_rise) begin
               state_nxt = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (tmo_hit) begin
               state_nxt = S_REPORT;
               rpt_tmo   = 1'b1;
            end else if (!echo_cur) begin
               state_nxt = S_REPORT;
            end
         end
         S_REPORT: begin
            state_nxt = S_GUARD;
         end
         S_GUARD: begin
            if (guard_done) begin
               state_nxt = enable ? S_TRIG : S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Width accumulator step. The rising-edge cycle is itself a high cycle,
   // so it is counted on top of freshly cleared counters.
   always_comb begin
      sub_base = (state == S_WAIT_RISE) ? '0 : sub_cnt;
      cm_base  = (state == S_WAIT_RISE) ? '0 : cm_cnt;
      if (sub_base == SUB_LAST) begin
         sub_inc = '0;
         cm_inc  = (cm_base == CM_SAT) ? cm_base : cm_base + 16'd1;
      end else begin
         sub_inc = sub_base + SUB_W'(1);
         cm_inc  = cm_base;
      end
   end

   assign count_en = ((state == S_WAIT_RISE) && echo_rise && !tmo_hit) ||
                     ((state == S_MEASURE) && echo_cur && !tmo_hit);

   // Counters and sensor pointer.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt  <= '0;
         tmo_cnt <= '0;
         sub_cnt <= '0;
         cm_cnt  <= '0;
         ptr     <= '0;
      end else begin
         if ((state == S_TRIG && !trig_done) || (state == S_GUARD && !guard_done)) begin
            ph_cnt <= ph_cnt + PH_W'(1);
         end else begin
            ph_cnt <= '0;
         end

         // Leaves WAIT_RISE/MEASURE at TMO_LAST, so it never exceeds
         // ECHO_TIMEOUT_CYC; cleared everywhere else, including TRIG.
         if (state == S_WAIT_RISE || state == S_MEASURE) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end else begin
            tmo_cnt <= '0;
         end

         if (count_en) begin
            sub_cnt <= sub_inc;
            cm_cnt  <= cm_inc;
         end

         // Pointer advances as GUARD is entered.
         if (state == S_REPORT) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + IDW'(1);
         end
      end
   end

   // Registered pin and report outputs.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         trig    <= '0;
         dist_cm <= '0;
         dist_id <= '0;
         timeout <= 1'b0;
      end else begin
         trig <= (state_nxt == S_TRIG) ? ptr_onehot : '0;
         if (state_nxt == S_REPORT && state != S_REPORT) begin
            dist_id <= ptr;
            timeout <= rpt_tmo;
            dist_cm <= rpt_tmo ? CM_NONE : cm_cnt;
         end
      end
   end

   assign dist_valid = (state == S_REPORT);
   assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_sonar_scan_sched.sv
// tb_sonar_scan_sched: table-driven sensor responses with a report scoreboard.
// Latency: reports are expected at exact cycles derived from trigger fall and echo timing.
// Backpressure: none; a monitor pops one expected record per dist_valid strobe.
`timescale 1ns/1ps
module tb_sonar_scan_sched;

   localparam int NS    = 4;
   localparam int TRIGC = 10;
   localparam int TMO   = 200;
   localparam int CPC   = 5;
   localparam int GRD   = 20;
   localparam int NV    = 14;

   logic          clk_50m = 1'b0;
   logic          rst_n   = 1'b0;
   logic          enable  = 1'b1;
   logic [NS-1:0] echo    = '1;
   logic [NS-1:0] trig;
   logic [15:0]   dist_cm;
   logic [1:0]    dist_id;
   logic          dist_valid;
   logic          timeout;
   logic          busy;

   sonar_scan_sched #(
      .NUM_SENS         (NS),
      .TRIG_CYC         (TRIGC),
      .ECHO_TIMEOUT_CYC (TMO),
      .CYC_PER_CM       (CPC),
      .GUARD_CYC        (GRD)
   ) dut (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .enable     (enable),
      .echo       (echo),
      .trig       (trig),
      .dist_cm    (dist_cm),
      .dist_id    (dist_id),
      .dist_valid (dist_valid),
      .timeout    (timeout),
      .busy       (busy)
   );

   always #10 clk_50m = ~clk_50m;

   typedef struct {
      int id;
      int pre;     // echo lines already high when the trigger falls
      int d;       // cycles from trigger fall to echo rise at the pin
      int w;       // echo high cycles at the pin, 0 = no echo
      int exp_cm;
      int exp_tmo;
   } vec_t;

   typedef struct {
      int id;
      int cm;
      int tmo;
      int due;
   } exp_t;

   vec_t tbl [NV];
   exp_t sb [$];
   int   cyc      = 0;
   int   n_vec    = 0;
   int   n_err    = 0;
   int   last_rpt = -1000;

   initial forever begin
      @(posedge clk_50m);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_50m);
   endtask

   // Returns the first negedge with trig[id] low after it was high.
   task automatic wait_trig_fall(input int id, output int f, output int hi, output int t_rise);
      int n;
      n = 0; f = -1; hi = 0; t_rise = -1;
      while (n < 1000) begin
         @(negedge clk_50m);
         n++;
         if (trig[id]) begin
            if (hi == 0) t_rise = cyc;
            hi++;
         end else if (hi > 0) begin
            f = cyc;
            return;
         end
      end
      n_err++;
      $display("FAIL trig_wait: sensor %0d trigger fall not seen within %0d cycles", id, n);
   endtask

   task automatic run_entry(input vec_t v, input int f);
      exp_t e;
      e.id  = v.id;
      e.cm  = v.exp_cm;
      e.tmo = v.exp_tmo;
      e.due = (v.exp_tmo != 0) ? f + TMO : f + v.d + v.w + 3;
      sb.push_back(e);
      if (v.pre != 0) begin
         wait_cyc(3);
         echo = '0;
         wait_cyc(v.d - 3);
      end else begin
         wait_cyc(v.d);
      end
      if (v.w > 0) begin
         echo[v.id] = 1'b1;
         wait_cyc(v.w);
         echo[v.id] = 1'b0;
      end
      while (cyc < e.due) @(negedge clk_50m);
   endtask

   // Monitor: one-hot triggers, guard gap, strobe width and scoreboard.
   initial begin
      exp_t          e;
      logic          prev_valid;
      logic [NS-1:0] prev_trig;
      prev_valid = 1'b0;
      prev_trig  = '0;
      forever begin
         @(negedge clk_50m);
         if ($countones(trig) > 1) begin
            n_err++;
            $display("FAIL trig_onehot: trig=%b, want at most one bit high", trig);
         end
         if (prev_trig == '0 && trig != '0) begin
            chk("guard_gap", 32'(cyc - last_rpt > GRD), 32'd1);
         end
         if (dist_valid) begin
            if (prev_valid) begin
               n_err++;
               $display("FAIL strobe_width: dist_valid high on consecutive cycles at %0d", cyc);
            end
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_report: id %0d cm %0h at cycle %0d, want no report", dist_id, dist_cm, cyc);
            end else begin
               e = sb.pop_front();
               chk("dist_id", 32'(dist_id), e.id);
               chk("dist_cm", 32'(dist_cm), e.cm);
               chk("timeout", 32'(timeout), e.tmo);
               chk("report_cycle", cyc, e.due);
            end
            last_rpt = cyc;
         end
         prev_valid = dist_valid;
         prev_trig  = trig;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int f, hi, tr, r, g, nz, nv;

      //             id pre  d    w   cm       tmo
      tbl[0]  = '{0, 1,  8,  52, 10,      0};
      tbl[1]  = '{1, 0,  0,  0,  'hFFFF,  1};
      tbl[2]  = '{2, 0,  2,  25, 5,       0};
      tbl[3]  = '{3, 0,  5,  25, 5,       0};
      tbl[4]  = '{0, 0,  2,  25, 5,       0};
      tbl[5]  = '{1, 0,  3,  25, 5,       0};
      tbl[6]  = '{2, 0,  1,  4,  0,       0};
      tbl[7]  = '{3, 0,  1,  5,  1,       0};
      tbl[8]  = '{0, 0,  1,  9,  1,       0};
      tbl[9]  = '{1, 0,  2,  190, 38,     0};
      tbl[10] = '{2, 0,  2,  210, 'hFFFF, 1};
      tbl[11] = '{3, 0,  2,  194, 38,     0};
      tbl[12] = '{0, 0,  2,  195, 'hFFFF, 1};
      tbl[13] = '{1, 0,  1,  25, 5,       0};

      // Reset held with enable and all echoes high.
      wait_cyc(5);
      chk("rst_trig",  32'(trig), 0);
      chk("rst_cm",    32'(dist_cm), 0);
      chk("rst_id",    32'(dist_id), 0);
      chk("rst_valid", 32'(dist_valid), 0);
      chk("rst_tmo",   32'(timeout), 0);
      chk("rst_busy",  32'(busy), 0);
      rst_n = 1'b1;
      r = cyc;
      wait_trig_fall(0, f, hi, tr);
      chk("first_trig_cycle", tr, r + 1);
      chk("trig_width", hi, TRIGC);

      for (int i = 0; i < NV; i++) begin
         if (i > 0) begin
            wait_trig_fall(tbl[i].id, f, hi, tr);
            chk("trig_width", hi, TRIGC);
         end
         run_entry(tbl[i], f);
      end

      // enable dropped while sensor 2 is measuring.
      wait_trig_fall(2, f, hi, tr);
      sb.push_back('{2, 6, 0, f + 35});
      wait_cyc(2);
      echo[2] = 1'b1;
      wait_cyc(8);
      enable = 1'b0;
      wait_cyc(22);
      echo[2] = 1'b0;
      while (cyc < f + 55) @(negedge clk_50m);
      chk("busy_in_guard", 32'(busy), 1);
      @(negedge clk_50m);
      chk("busy_after_guard", 32'(busy), 0);
      nz = 0;
      repeat (30) begin
         @(negedge clk_50m);
         if (trig != '0 || busy) nz++;
      end
      chk("idle_no_trig", nz, 0);
      chk("hold_cm", 32'(dist_cm), 6);
      chk("hold_id", 32'(dist_id), 2);
      chk("hold_tmo", 32'(timeout), 0);
      enable = 1'b1;
      g = cyc;
      @(negedge clk_50m);
      chk("resume_trig", 32'(trig), 32'b1000);
      chk("resume_cycle", cyc, g + 1);

      // Reset in the middle of sensor 3's measurement.
      wait_trig_fall(3, f, hi, tr);
      wait_cyc(2);
      echo[3] = 1'b1;
      wait_cyc(8);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_trig", 32'(trig), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_cm",   32'(dist_cm), 0);
      chk("sb_empty_at_reset", sb.size(), 0);
      wait_cyc(3);
      rst_n = 1'b1;
      @(negedge clk_50m);
      chk("ptr_after_reset", 32'(trig), 32'b0001);

      // Reset while a trigger is high drops it without waiting for a clock.
      wait_cyc(3);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_in_trig", 32'(trig), 0);
      @(negedge clk_50m);
      rst_n = 1'b1;
      @(negedge clk_50m);
      chk("trig_after_rerelease", 32'(trig), 32'b0001);

      nv = 0;
      repeat (60) begin
         @(negedge clk_50m);
         if (dist_valid) nv++;
      end
      chk("no_aborted_report", nv, 0);
      echo = '0;
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
